// File: rtl/conv_layer_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : conv_layer_scheduler
// Description : Drives the shared Conv2d datapath through NUM_LAYERS binary
//               conv layers.  For each layer it streams OC weight words from
//               weight memory into the Conv2d weight bank, holds conv_en
//               (Conv2d data_in_ready) until conv_done (data_out_ready)
//               returns, and then pulses a ping-pong image-buffer swap.
//               After the last layer it emits a one-cycle done pulse.
//
// Ports       : clk, rst        clock (rising edge), synchronous active-high reset
//               start           begin an inference pass (sampled in IDLE only)
//               busy, done, err status; done is a 1-cycle pulse, err is sticky
//               layer_idx       current layer
//               conv_en         Conv2d data_in_ready level
//               conv_done       Conv2d data_out_ready
//               wmem_rd/addr    weight memory read strobe and address
//               wmem_rdata      read data, valid one cycle after wmem_rd
//               wbank_we/idx    weight bank write strobe and slot
//               wbank_data      weight bank write data (= wmem_rdata)
//               buf_swap        1-cycle ping-pong image buffer swap
//
// Options     : `define SCHED_TIMEOUT_EN to add a RUN watchdog of TIMEOUT_CYC
//               cycles that sets err and returns to IDLE without swap/done.
//
// Revision    : 1.0 - initial release
// ============================================================================
module conv_layer_scheduler #(
    parameter int NUM_LAYERS  = 2,
    parameter int OC          = 8,
    parameter int WEIGHT_W    = 36,
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic                                                   start,
    output logic                                                   busy,
    output logic                                                   done,
    output logic                                                   err,
    output logic [((NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1)-1:0] layer_idx,
    output logic                                                   conv_en,
    input  logic                                                   conv_done,
    output logic                                                   wmem_rd,
    output logic [ADDR_W-1:0]                                      wmem_addr,
    input  logic [WEIGHT_W-1:0]                                    wmem_rdata,
    output logic                                                   wbank_we,
    output logic [((OC > 1) ? $clog2(OC) : 1)-1:0]                 wbank_idx,
    output logic [WEIGHT_W-1:0]                                    wbank_data,
    output logic                                                   buf_swap
);

    localparam int LAYER_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int K_W     = (OC > 1) ? $clog2(OC) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_LWAIT = 3'd2,
        S_RUN   = 3'd3,
        S_SWAP  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [K_W-1:0]       r_k;        // load counter: slot being read this cycle
    logic [LAYER_W-1:0]   r_layer;
    logic [ADDR_W-1:0]    r_base;     // layer_idx*OC kept as a running sum
    logic                 r_we;
    logic [K_W-1:0]       r_wr_idx;

    logic                 w_k_last;
    logic                 w_layer_last;
    logic                 w_tmo;

    assign w_k_last     = (r_k == K_W'(OC - 1));
    assign w_layer_last = (r_layer == LAYER_W'(NUM_LAYERS - 1));

    // ------------------------------------------------------------------------
    // Optional RUN watchdog
    // ------------------------------------------------------------------------
`ifdef SCHED_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_err;

    // Counter is zero on the first RUN cycle, so the watchdog fires on the
    // TIMEOUT_CYC-th RUN cycle; conv_done in that same cycle still wins.
    assign w_tmo = (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            if (r_state == S_RUN) begin
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end else begin
                r_tmo_cnt <= '0;
            end

            if (r_state == S_IDLE && start) begin
                r_err <= 1'b0;
            end else if (r_state == S_RUN && !conv_done && w_tmo) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    // Watchdog compiled out: the condition is constant false and RUN waits
    // for conv_done indefinitely.
    assign w_tmo = (TIMEOUT_CYC < 0);
    assign err   = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // State register and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_k      <= '0;
            r_layer  <= '0;
            r_base   <= '0;
            r_we     <= 1'b0;
            r_wr_idx <= '0;
        end else begin
            r_state <= w_state_next;

            // Memory has one cycle of read latency, so the bank write for a
            // slot follows its read by exactly one cycle.
            r_we <= wmem_rd;
            if (wmem_rd) begin
                r_wr_idx <= r_k;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_k     <= '0;
                        r_layer <= '0;
                        r_base  <= '0;
                    end
                end
                S_LOAD: begin
                    r_k <= r_k + K_W'(1);
                end
                S_SWAP: begin
                    if (!w_layer_last) begin
                        r_k     <= '0;
                        r_layer <= r_layer + LAYER_W'(1);
                        r_base  <= r_base + ADDR_W'(OC);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and control outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b1;
        done         = 1'b0;
        conv_en      = 1'b0;
        wmem_rd      = 1'b0;
        buf_swap     = 1'b0;

        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                wmem_rd = 1'b1;
                if (w_k_last) begin
                    w_state_next = S_LWAIT;
                end
            end
            S_LWAIT: begin
                // Last bank write lands here; conv_en stays low so the bank
                // is never written while Conv2d is running.
                w_state_next = S_RUN;
            end
            S_RUN: begin
                conv_en = 1'b1;
                if (conv_done) begin
                    w_state_next = S_SWAP;
                end else if (w_tmo) begin
                    w_state_next = S_IDLE;
                end
            end
            S_SWAP: begin
                buf_swap = 1'b1;
                if (w_layer_last) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_LOAD;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                busy         = 1'b0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign layer_idx  = r_layer;
    assign wmem_addr  = (r_state == S_LOAD) ? (r_base + ADDR_W'(r_k)) : '0;
    assign wbank_we   = r_we;
    assign wbank_idx  = r_wr_idx;
    assign wbank_data = wmem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_conv_layer_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_layer_scheduler
// Description : Scoreboard bench for conv_layer_scheduler.  Stimulus pushes
//               the expected reads, bank writes, RUN lengths, swaps and done
//               latency into queues; a negedge monitor pops and compares
//               whenever the DUT presents the matching event.  Includes a
//               one-cycle-latency weight memory and a Conv2d model that
//               answers conv_done after run_r cycles of conv_en.
//               Build with +define+SCHED_TIMEOUT_EN to add the watchdog test.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_conv_layer_scheduler;

    localparam int NL = 2;
    localparam int OC = 4;
    localparam int WW = 36;
    localparam int AW = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, err, conv_en, wmem_rd, wbank_we, buf_swap;
    logic [0:0]    layer_idx;
    logic          conv_done = 1'b0;
    logic [AW-1:0] wmem_addr;
    logic [WW-1:0] wmem_rdata = '0;
    logic [1:0]    wbank_idx;
    logic [WW-1:0] wbank_data;

    conv_layer_scheduler #(
        .NUM_LAYERS  (NL),
        .OC          (OC),
        .WEIGHT_W    (WW),
        .ADDR_W      (AW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .layer_idx  (layer_idx),
        .conv_en    (conv_en),
        .conv_done  (conv_done),
        .wmem_rd    (wmem_rd),
        .wmem_addr  (wmem_addr),
        .wmem_rdata (wmem_rdata),
        .wbank_we   (wbank_we),
        .wbank_idx  (wbank_idx),
        .wbank_data (wbank_data),
        .buf_swap   (buf_swap)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic unexp(input string nm, input longint v);
        total++;
        bad++;
        $display("FAIL %s: unexpected event value %0h, none expected at %0t", nm, v, $time);
    endtask

    function automatic logic [WW-1:0] wdat(input logic [AW-1:0] a);
        return {4'hA, a ^ 8'h5A, 16'hC3E1, a};
    endfunction

    // ---------------- scoreboard queues ----------------
    typedef struct { int a; int b; } pair_t;
    pair_t q_rd[$];    // (address, layer)
    pair_t q_wr[$];    // (slot, source address)
    int    q_run[$];   // conv_en high length
    int    q_swap[$];  // layer_idx at swap
    int    q_done[$];  // busy cycles up to and including done

    task automatic push_layer(input int l, input int r, input bit full);
        for (int k = 0; k < OC; k++) begin
            q_rd.push_back('{l * OC + k, l});
            q_wr.push_back('{k, l * OC + k});
        end
        if (full) begin
            q_run.push_back(r);
            q_swap.push_back(l);
        end
    endtask

    task automatic push_pass(input int r);
        for (int l = 0; l < NL; l++) push_layer(l, r, 1'b1);
        q_done.push_back(NL * (OC + 1 + r + 1) + 1);
    endtask

    task automatic check_empty();
        chk("q_rd_left",   q_rd.size(),   0);
        chk("q_wr_left",   q_wr.size(),   0);
        chk("q_run_left",  q_run.size(),  0);
        chk("q_swap_left", q_swap.size(), 0);
        chk("q_done_left", q_done.size(), 0);
    endtask

    // ---------------- models ----------------
    int run_r    = 5;
    bit force_cd = 1'b0;   // hold conv_done high while conv_en is low
    int cd_cnt   = 0;

    always @(negedge clk) begin
        if (conv_en) cd_cnt = cd_cnt + 1;
        else         cd_cnt = 0;
        conv_done = (conv_en && cd_cnt >= run_r) || (!conv_en && force_cd);
    end

    logic          mem_rd_s;
    logic [AW-1:0] mem_a_s;
    always begin
        @(negedge clk);
        mem_rd_s = wmem_rd;
        mem_a_s  = wmem_addr;
        @(posedge clk);
        #1;
        if (mem_rd_s) wmem_rdata = wdat(mem_a_s);
    end

    // ---------------- monitor ----------------
    int    busy_cnt  = 0;
    int    run_len   = 0;
    int    gap_cnt   = 0;
    bit    gap_armed = 1'b0;
    bit    prev_rd   = 1'b0;
    bit    abort_run = 1'b0;
    pair_t mp;

    always @(negedge clk) begin
        busy_cnt = busy ? busy_cnt + 1 : 0;
        chk("we_pipe", wbank_we, prev_rd);
        if (wmem_rd) begin
            if (q_rd.size() == 0) unexp("read", wmem_addr);
            else begin
                mp = q_rd.pop_front();
                chk("rd_addr", wmem_addr, mp.a);
                chk("rd_layer", layer_idx, mp.b);
            end
        end
        if (wbank_we) begin
            chk("we_with_conv_en", conv_en, 0);
            if (q_wr.size() == 0) unexp("write", wbank_idx);
            else begin
                mp = q_wr.pop_front();
                chk("wr_idx", wbank_idx, mp.a);
                chk("wr_data", wbank_data, wdat(8'(mp.b)));
            end
        end
        if (buf_swap) begin
            if (q_swap.size() == 0) unexp("swap", layer_idx);
            else chk("swap_layer", layer_idx, q_swap.pop_front());
        end
        if (done) begin
            if (q_done.size() == 0) unexp("done", busy_cnt);
            else chk("done_latency", busy_cnt, q_done.pop_front());
        end
        if (conv_en) begin
            if (gap_armed) chk("conv_en_gap_ok", gap_cnt >= OC + 2, 1);
            gap_armed = 1'b0;
            gap_cnt   = 0;
            run_len++;
        end else begin
            gap_cnt++;
            if (run_len > 0) begin
                if (abort_run) abort_run = 1'b0;
                else if (q_run.size() == 0) unexp("run", run_len);
                else chk("run_len", run_len, q_run.pop_front());
                run_len   = 0;
                gap_armed = busy;
            end
            if (!busy) gap_armed = 1'b0;
        end
        prev_rd = wmem_rd;
    end

    // ---------------- stimulus ----------------
    // Pulse start, optionally re-pulse it during LOAD, RUN and DONE, and wait
    // (bounded) for the done pulse.
    task automatic drive_pass(input bit extra);
        bit seen = 1'b0;
        bit p1 = 1'b0;
        bit p2 = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 0) chk("err_cleared_by_start", err, 0);
            if (extra) begin
                if (wmem_rd && !p1) begin start = 1'b1; p1 = 1'b1; end
                else if (conv_en && !p2) begin start = 1'b1; p2 = 1'b1; end
                else if (done) start = 1'b1;
            end
            if (done) begin seen = 1'b1; break; end
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL pass_timeout: done not seen within 400 cycles");
        end
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check_empty();
    endtask

    task automatic run_pass(input int r, input bit extra);
        run_r = r;
        push_pass(r);
        drive_pass(extra);
    endtask

    initial begin
        // 1: reset with start and conv_done held high
        rst = 1'b1; start = 1'b1; force_cd = 1'b1;
        @(negedge clk);
        repeat (2) begin
            @(negedge clk);
            chk("rst_outputs", {busy, done, err, conv_en, wmem_rd, wbank_we, buf_swap,
                                layer_idx, wmem_addr, wbank_idx}, 0);
            chk("rst_conv_done_held", conv_done, 1);
        end
        rst = 1'b0; start = 1'b0; force_cd = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_busy", busy, 0);

        // 2: basic two-layer pass, RUN length 5 -> 23 busy cycles
        run_pass(5, 1'b0);

        // 3: start pulses during LOAD, RUN and DONE are ignored
        run_pass(4, 1'b1);

        // 4: reset during RUN of layer 1, then a clean restart
        run_r = 20;
        push_layer(0, 20, 1'b1);
        push_layer(1, 20, 1'b0);
        @(negedge clk);
        start = 1'b1;
        begin
            bit hit = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                start = 1'b0;
                if (conv_en && layer_idx == 1'b1) begin hit = 1'b1; break; end
            end
            chk("reached_layer1_run", hit, 1);
        end
        repeat (2) @(negedge clk);
        abort_run = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_conv_en", conv_en, 0);
        chk("abort_layer_idx", layer_idx, 0);
        chk("abort_busy", busy, 0);
        chk("abort_swap_done", {buf_swap, done}, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_empty();
        run_pass(5, 1'b0);

        // 5: conv_done forced during LOAD/LWAIT must not cut RUN short
        force_cd = 1'b1;
        run_pass(3, 1'b0);
        force_cd = 1'b0;

        // 6: watchdog
`ifdef SCHED_TIMEOUT_EN
        run_r = 1000;
        push_layer(0, TO, 1'b0);
        q_run.push_back(TO);
        @(negedge clk);
        start = 1'b1;
        begin
            bit seen = 1'b0;
            int n = 0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                start = 1'b0;
                if (conv_en) n++;
                if (err) begin seen = 1'b1; break; end
            end
            chk("tmo_err_set", seen, 1);
            chk("tmo_run_cycles", n, TO);
            chk("tmo_conv_en", conv_en, 0);
            chk("tmo_busy", busy, 0);
        end
        repeat (4) @(negedge clk);
        chk("tmo_err_sticky", err, 1);
        check_empty();
        run_pass(2, 1'b0);
`endif
        chk("err_final", err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
